// File: rtl/branch_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl_if
// Bundles the signals between the ID-stage branch hazard controller and the
// pipeline around it.
//   master : the pipeline side. It drives the IF/ID opcode and sources, the
//            ID/EX, EX/MEM and MEM/WB destination info, and the comparator
//            result. It receives the stall, flush and forward selects.
//   slave  : the controller. It has the opposite directions.
// Signal summary:
//   id_op[5:0], id_rs[4:0], id_rt[4:0]        branch in IF/ID
//   idex_regwr, idex_memrd, idex_rd[4:0]      producer in ID/EX
//   exmem_regwr, exmem_memrd, exmem_rd[4:0]   producer in EX/MEM
//   memwb_regwr, memwb_rd[4:0]                producer in MEM/WB
//   take_branch                               comparator result
//   fa, fb [1:0]                              00 regfile, 01 MEMWB, 10 EXMEM
//   stall, resolve, flush_ifid                pipeline control
//   br_cnt, taken_cnt, stall_cnt [CNT_W-1:0]  saturating statistics
// ---------------------------------------------------------------------------
interface branch_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       id_op;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             idex_regwr;
    logic             idex_memrd;
    logic [4:0]       idex_rd;
    logic             exmem_regwr;
    logic             exmem_memrd;
    logic [4:0]       exmem_rd;
    logic             memwb_regwr;
    logic [4:0]       memwb_rd;
    logic             take_branch;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             stall;
    logic             resolve;
    logic             flush_ifid;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_op, id_rs, id_rt,
        output idex_regwr, idex_memrd, idex_rd,
        output exmem_regwr, exmem_memrd, exmem_rd,
        output memwb_regwr, memwb_rd,
        output take_branch,
        input  fa, fb, stall, resolve, flush_ifid,
        input  br_cnt, taken_cnt, stall_cnt
    );

    modport slave (
        input  id_op, id_rs, id_rt,
        input  idex_regwr, idex_memrd, idex_rd,
        input  exmem_regwr, exmem_memrd, exmem_rd,
        input  memwb_regwr, memwb_rd,
        input  take_branch,
        output fa, fb, stall, resolve, flush_ifid,
        output br_cnt, taken_cnt, stall_cnt
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
// Sequences BEQ resolution in the ID stage. It finds operand hazards for the
// ID-stage comparator and stalls IF/ID for 0-2 cycles. On the resolve cycle it
// drives the forward selects fa/fb. It flushes IF/ID when the branch is taken
// and keeps saturating statistics counters.
// Ports:
//   clock : pipeline clock
//   reset : asynchronous, active-high
//   bus   : branch_hazard_ctrl_if.slave (see interface header)
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
    parameter logic [5:0] BEQ_OP = 6'b000100,
    parameter int         CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    branch_hazard_ctrl_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_reg;
    logic [1:0]       wcnt_reg;
    logic [CNT_W-1:0] br_cnt_reg;
    logic [CNT_W-1:0] taken_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic [4:0] src   [2];
    logic [1:0] need  [2];
    logic [1:0] fwd   [2];
    logic [1:0] nmax;
    logic       is_beq;
    logic       stall_c;
    logic       resolve_c;

    assign src[0] = bus.id_rs;
    assign src[1] = bus.id_rt;

    // Per-source hazard depth and forward choice. $0 never matches.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic nz, m_idex, m_exmem, m_memwb;
            assign nz      = (src[gi] != 5'd0);
            assign m_idex  = bus.idex_regwr  && (bus.idex_rd  == src[gi]) && nz;
            assign m_exmem = bus.exmem_regwr && (bus.exmem_rd == src[gi]) && nz;
            assign m_memwb = bus.memwb_regwr && (bus.memwb_rd == src[gi]) && nz;

            assign need[gi] = (m_idex && bus.idex_memrd)                  ? 2'd2 :
                              ((m_idex && !bus.idex_memrd) ||
                               (m_exmem && bus.exmem_memrd))              ? 2'd1 : 2'd0;

            // EX/MEM ALU result beats the older MEM/WB value.
            assign fwd[gi]  = (m_exmem && !bus.exmem_memrd) ? 2'b10 :
                              m_memwb                       ? 2'b01 : 2'b00;
        end
    endgenerate

    assign nmax   = (need[0] > need[1]) ? need[0] : need[1];
    assign is_beq = (bus.id_op == BEQ_OP);

    always_comb begin
        stall_c   = 1'b0;
        resolve_c = 1'b0;
        case (state_reg)
            IDLE: begin
                if (is_beq) begin
                    if (nmax == 2'd0) resolve_c = 1'b1;
                    else              stall_c   = 1'b1;
                end
            end
            WAIT: begin
                // The branch is held in IF/ID while waiting, so id_op is not rechecked.
                if (wcnt_reg != 2'd0) stall_c   = 1'b1;
                else                  resolve_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            wcnt_reg      <= 2'd0;
            br_cnt_reg    <= '0;
            taken_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_beq && (nmax != 2'd0)) begin
                        wcnt_reg  <= nmax - 2'd1;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt_reg != 2'd0) wcnt_reg  <= wcnt_reg - 2'd1;
                    else                  state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            if (resolve_c && (br_cnt_reg != '1))
                br_cnt_reg <= br_cnt_reg + 1'b1;
            if (resolve_c && bus.take_branch && (taken_cnt_reg != '1))
                taken_cnt_reg <= taken_cnt_reg + 1'b1;
            if (stall_c && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign bus.stall      = stall_c;
    assign bus.resolve    = resolve_c;
    assign bus.flush_ifid = resolve_c && bus.take_branch;
    assign bus.fa         = resolve_c ? fwd[0] : 2'b00;
    assign bus.fb         = resolve_c ? fwd[1] : 2'b00;
    assign bus.br_cnt     = br_cnt_reg;
    assign bus.taken_cnt  = taken_cnt_reg;
    assign bus.stall_cnt  = stall_cnt_reg;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;
    logic clock;
    logic reset;
    int   tests;
    int   fails;

    branch_hazard_ctrl_if #(.CNT_W(16)) bus ();
    branch_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

    branch_hazard_ctrl #(.BEQ_OP(6'b000100), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .bus(bus));
    branch_hazard_ctrl #(.BEQ_OP(6'b000100), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_op = 6'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        bus.idex_regwr = 0; bus.idex_memrd = 0; bus.idex_rd = 5'd0;
        bus.exmem_regwr = 0; bus.exmem_memrd = 0; bus.exmem_rd = 5'd0;
        bus.memwb_regwr = 0; bus.memwb_rd = 5'd0; bus.take_branch = 0;
    endtask

    task automatic clear_inputs4();
        bus4.id_op = 6'd0; bus4.id_rs = 5'd0; bus4.id_rt = 5'd0;
        bus4.idex_regwr = 0; bus4.idex_memrd = 0; bus4.idex_rd = 5'd0;
        bus4.exmem_regwr = 0; bus4.exmem_memrd = 0; bus4.exmem_rd = 5'd0;
        bus4.memwb_regwr = 0; bus4.memwb_rd = 5'd0; bus4.take_branch = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        clear_inputs4();
        #2;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        tests++; if (bus.resolve !== 1'b0) begin fails++; $display("FAIL reset_resolve got %b want 0", bus.resolve); end
        tests++; if (bus.br_cnt !== 16'd0) begin fails++; $display("FAIL reset_br_cnt got %0d want 0", bus.br_cnt); end
        tests++; if (bus.stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall_cnt got %0d want 0", bus.stall_cnt); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        $display("[TB] reset done");
    endtask

    // BEQ $1,$2 with nothing in flight, taken.
    task automatic test_no_hazard();
        tick();
        bus.id_op = 6'b000100; bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.take_branch = 1;
        #1;
        tests++; if (bus.resolve !== 1'b1) begin fails++; $display("FAIL t1_resolve got %b want 1", bus.resolve); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL t1_stall got %b want 0", bus.stall); end
        tests++; if ({bus.fa, bus.fb} !== 4'b0000) begin fails++; $display("FAIL t1_fwd got %b%b want 0000", bus.fa, bus.fb); end
        tests++; if (bus.flush_ifid !== 1'b1) begin fails++; $display("FAIL t1_flush got %b want 1", bus.flush_ifid); end
        tick();
        clear_inputs();
        #1;
        tests++; if (bus.br_cnt !== 16'd1) begin fails++; $display("FAIL t1_br_cnt got %0d want 1", bus.br_cnt); end
        tests++; if (bus.taken_cnt !== 16'd1) begin fails++; $display("FAIL t1_taken_cnt got %0d want 1", bus.taken_cnt); end
        tests++; if (bus.flush_ifid !== 1'b0) begin fails++; $display("FAIL t1_idle_flush got %b want 0", bus.flush_ifid); end
        $display("[TB] no-hazard BEQ done");
    endtask

    // ADD $3 in EX, then BEQ $3,$4: one stall, then fa=10.
    task automatic test_alu_fwd();
        tick();
        bus.id_op = 6'b000100; bus.id_rs = 5'd3; bus.id_rt = 5'd4;
        bus.idex_regwr = 1; bus.idex_rd = 5'd3;
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL t2_stall got %b want 1", bus.stall); end
        tests++; if (bus.resolve !== 1'b0) begin fails++; $display("FAIL t2_noresolve got %b want 0", bus.resolve); end
        tick();
        bus.idex_regwr = 0; bus.idex_rd = 5'd0;
        bus.exmem_regwr = 1; bus.exmem_rd = 5'd3;
        #1;
        tests++; if (bus.resolve !== 1'b1) begin fails++; $display("FAIL t2_resolve got %b want 1", bus.resolve); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL t2_stall2 got %b want 0", bus.stall); end
        tests++; if (bus.fa !== 2'b10) begin fails++; $display("FAIL t2_fa got %b want 10", bus.fa); end
        tests++; if (bus.fb !== 2'b00) begin fails++; $display("FAIL t2_fb got %b want 00", bus.fb); end
        tests++; if (bus.flush_ifid !== 1'b0) begin fails++; $display("FAIL t2_flush got %b want 0", bus.flush_ifid); end
        tick();
        clear_inputs();
        #1;
        tests++; if (bus.stall_cnt !== 16'd1) begin fails++; $display("FAIL t2_stall_cnt got %0d want 1", bus.stall_cnt); end
        tests++; if (bus.br_cnt !== 16'd2) begin fails++; $display("FAIL t2_br_cnt got %0d want 2", bus.br_cnt); end
        $display("[TB] alu-forward BEQ done");
    endtask

    // LW $5 in EX, then BEQ $0,$5: two stalls, then fb=01.
    task automatic test_load_stall();
        tick();
        bus.id_op = 6'b000100; bus.id_rs = 5'd0; bus.id_rt = 5'd5; bus.take_branch = 1;
        bus.idex_regwr = 1; bus.idex_memrd = 1; bus.idex_rd = 5'd5;
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL t3_stall1 got %b want 1", bus.stall); end
        tests++; if (bus.flush_ifid !== 1'b0) begin fails++; $display("FAIL t3_flush_stall got %b want 0", bus.flush_ifid); end
        tick();
        bus.idex_regwr = 0; bus.idex_memrd = 0; bus.idex_rd = 5'd0;
        bus.exmem_regwr = 1; bus.exmem_memrd = 1; bus.exmem_rd = 5'd5;
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL t3_stall2 got %b want 1", bus.stall); end
        tests++; if (bus.resolve !== 1'b0) begin fails++; $display("FAIL t3_noresolve got %b want 0", bus.resolve); end
        tick();
        bus.exmem_regwr = 0; bus.exmem_memrd = 0; bus.exmem_rd = 5'd0;
        bus.memwb_regwr = 1; bus.memwb_rd = 5'd5;
        #1;
        tests++; if (bus.resolve !== 1'b1) begin fails++; $display("FAIL t3_resolve got %b want 1", bus.resolve); end
        tests++; if (bus.fa !== 2'b00) begin fails++; $display("FAIL t3_fa got %b want 00", bus.fa); end
        tests++; if (bus.fb !== 2'b01) begin fails++; $display("FAIL t3_fb got %b want 01", bus.fb); end
        tests++; if (bus.flush_ifid !== 1'b1) begin fails++; $display("FAIL t3_flush got %b want 1", bus.flush_ifid); end
        tick();
        clear_inputs();
        #1;
        tests++; if (bus.stall_cnt !== 16'd3) begin fails++; $display("FAIL t3_stall_cnt got %0d want 3", bus.stall_cnt); end
        tests++; if (bus.taken_cnt !== 16'd2) begin fails++; $display("FAIL t3_taken_cnt got %0d want 2", bus.taken_cnt); end
        $display("[TB] load-stall BEQ done");
    endtask

    // Load writing $0 in ID/EX must not stall BEQ $0,$0.
    task automatic test_zero_reg();
        tick();
        bus.id_op = 6'b000100; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        bus.idex_regwr = 1; bus.idex_memrd = 1; bus.idex_rd = 5'd0;
        bus.exmem_regwr = 1; bus.exmem_rd = 5'd0;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL zero_stall got %b want 0", bus.stall); end
        tests++; if (bus.resolve !== 1'b1) begin fails++; $display("FAIL zero_resolve got %b want 1", bus.resolve); end
        tests++; if ({bus.fa, bus.fb} !== 4'b0000) begin fails++; $display("FAIL zero_fwd got %b%b want 0000", bus.fa, bus.fb); end
        tick();
        clear_inputs();
        $display("[TB] zero-register BEQ done");
    endtask

    // EXMEM and MEMWB both write $6; EXMEM wins for both sources.
    task automatic test_priority();
        tick();
        bus.id_op = 6'b000100; bus.id_rs = 5'd6; bus.id_rt = 5'd6;
        bus.exmem_regwr = 1; bus.exmem_rd = 5'd6;
        bus.memwb_regwr = 1; bus.memwb_rd = 5'd6;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL t4_stall got %b want 0", bus.stall); end
        tests++; if (bus.fa !== 2'b10) begin fails++; $display("FAIL t4_fa got %b want 10", bus.fa); end
        tests++; if (bus.fb !== 2'b10) begin fails++; $display("FAIL t4_fb got %b want 10", bus.fb); end
        tick();
        clear_inputs();
        #1;
        tests++; if (bus.br_cnt !== 16'd5) begin fails++; $display("FAIL t4_br_cnt got %0d want 5", bus.br_cnt); end
        $display("[TB] forward-priority BEQ done");
    endtask

    // Non-branch opcode with a load hazard present: nothing happens.
    task automatic test_non_branch();
        tick();
        bus.id_op = 6'b100011; bus.id_rs = 5'd7; bus.id_rt = 5'd8;
        bus.idex_regwr = 1; bus.idex_memrd = 1; bus.idex_rd = 5'd7;
        bus.exmem_regwr = 1; bus.exmem_rd = 5'd8; bus.take_branch = 1;
        #1;
        tests++; if ({bus.stall, bus.resolve, bus.flush_ifid} !== 3'b000) begin fails++; $display("FAIL nb_ctrl got %b want 000", {bus.stall, bus.resolve, bus.flush_ifid}); end
        tests++; if ({bus.fa, bus.fb} !== 4'b0000) begin fails++; $display("FAIL nb_fwd got %b%b want 0000", bus.fa, bus.fb); end
        tick();
        clear_inputs();
        #1;
        tests++; if (bus.stall_cnt !== 16'd3) begin fails++; $display("FAIL nb_stall_cnt got %0d want 3", bus.stall_cnt); end
        $display("[TB] non-branch done");
    endtask

    // Reset in the 2nd cycle of a load stall; BEQ stays in IF/ID with no hazard left.
    task automatic test_reset_mid_wait();
        tick();
        bus.id_op = 6'b000100; bus.id_rs = 5'd5; bus.id_rt = 5'd9;
        bus.idex_regwr = 1; bus.idex_memrd = 1; bus.idex_rd = 5'd5;
        tick();
        bus.idex_regwr = 0; bus.idex_memrd = 0; bus.idex_rd = 5'd0;
        bus.exmem_regwr = 1; bus.exmem_memrd = 1; bus.exmem_rd = 5'd9;
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL t5_prestall got %b want 1", bus.stall); end
        reset = 1'b1;
        bus.exmem_regwr = 0; bus.exmem_memrd = 0; bus.exmem_rd = 5'd0;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL t5_stall got %b want 0", bus.stall); end
        tests++; if (bus.resolve !== 1'b1) begin fails++; $display("FAIL t5_idle_resolve got %b want 1", bus.resolve); end
        tests++; if (bus.br_cnt !== 16'd0) begin fails++; $display("FAIL t5_br_cnt got %0d want 0", bus.br_cnt); end
        tests++; if (bus.stall_cnt !== 16'd0) begin fails++; $display("FAIL t5_stall_cnt got %0d want 0", bus.stall_cnt); end
        #1;
        reset = 1'b0;
        tick();
        clear_inputs();
        #1;
        tests++; if (bus.br_cnt !== 16'd1) begin fails++; $display("FAIL t5_after_br got %0d want 1", bus.br_cnt); end
        tests++; if (bus.stall_cnt !== 16'd0) begin fails++; $display("FAIL t5_after_stall got %0d want 0", bus.stall_cnt); end
        $display("[TB] reset mid-wait done");
    endtask

    // 4-bit counters: 17 taken resolves, then a repeating load-stall pattern.
    task automatic test_saturate();
        tick();
        bus4.id_op = 6'b000100; bus4.id_rs = 5'd1; bus4.id_rt = 5'd2; bus4.take_branch = 1;
        for (int i = 0; i < 15; i++) tick();
        tests++; if (bus4.br_cnt !== 4'd15) begin fails++; $display("FAIL sat_br15 got %0d want 15", bus4.br_cnt); end
        tick();
        tick();
        tests++; if (bus4.br_cnt !== 4'd15) begin fails++; $display("FAIL sat_br_hold got %0d want 15", bus4.br_cnt); end
        tests++; if (bus4.taken_cnt !== 4'd15) begin fails++; $display("FAIL sat_taken_hold got %0d want 15", bus4.taken_cnt); end
        tests++; if (bus4.stall_cnt !== 4'd0) begin fails++; $display("FAIL sat_stall0 got %0d want 0", bus4.stall_cnt); end
        bus4.idex_regwr = 1; bus4.idex_memrd = 1; bus4.idex_rd = 5'd1;
        for (int i = 0; i < 30; i++) tick();
        tests++; if (bus4.stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_stall_hold got %0d want 15", bus4.stall_cnt); end
        clear_inputs4();
        $display("[TB] saturation done");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_no_hazard();
        test_alu_fwd();
        test_load_stall();
        test_zero_reg();
        test_priority();
        test_non_branch();
        test_reset_mid_wait();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
